// File: rtl/sram_bridge.sv
// Splits one wide CPU access into narrow asynchronous-SRAM beats with registered
// CS/OE/WE strobes, a write-data hold cycle after WE rises, and little-endian read reassembly.
module sram_bridge #(
  parameter int CPU_DW      = 32,
  parameter int SRAM_DW     = 16,
  parameter int CPU_AW      = 20,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               rnw,
  input  logic [CPU_AW-1:0]  addr,
  input  logic [CPU_DW-1:0]  wdata,
  output logic [CPU_DW-1:0]  rdata,
  output logic               ack,
  output logic               busy,
  output logic [SRAM_AW-1:0] sram_adr,
  output logic [SRAM_DW-1:0] sram_dout,
  output logic               sram_den,
  input  logic [SRAM_DW-1:0] sram_din,
  output logic               ram_cs_b,
  output logic               ram_oe_b,
  output logic               ram_we_b
);

  localparam int BEATS = CPU_DW / SRAM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 0;
  localparam int CW    = (BW > 0) ? BW : 1;
  localparam int WW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t              state;
  logic                rnw_q;
  logic [CPU_AW-1:0]   addr_q;
  logic [CPU_DW-1:0]   wdata_q;
  logic [CPU_DW-1:0]   rbuf;
  logic [CW-1:0]       beat;
  logic [CW-1:0]       beat_nx;
  logic [WW-1:0]       wcnt;
  logic                accept;
  logic                strobe_last;
  logic                last_beat;
  logic                capture;

  // With a single beat the counter bit is unused and is shifted out of the address.
  function automatic logic [SRAM_AW-1:0] beat_adr(input logic [CPU_AW-1:0] a,
                                                  input logic [CW-1:0] b);
    logic [CPU_AW+CW-1:0] full;
    full = {a, b} >> (CW - BW);
    return full[SRAM_AW-1:0];
  endfunction

  function automatic logic [SRAM_DW-1:0] slice_of(input logic [CPU_DW-1:0] d,
                                                  input logic [CW-1:0] b);
    return d[b*SRAM_DW +: SRAM_DW];
  endfunction

  function automatic logic [CPU_DW-1:0] merge(input logic [CPU_DW-1:0] d,
                                              input logic [CW-1:0] b,
                                              input logic [SRAM_DW-1:0] s);
    logic [CPU_DW-1:0] r;
    r = d;
    r[b*SRAM_DW +: SRAM_DW] = s;
    return r;
  endfunction

  assign accept      = (state == IDLE) && req;
  assign strobe_last = (wcnt == WW'(WAIT_STATES));
  assign last_beat   = (beat == CW'(BEATS - 1));
  assign beat_nx     = beat + 1'b1;
  assign capture     = (state == STROBE) && rnw_q && strobe_last;

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
    if (capture) rbuf <= merge(rbuf, beat, sram_din);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rnw_q     <= 1'b0;
      beat      <= '0;
      wcnt      <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      sram_adr  <= '0;
      sram_dout <= '0;
      sram_den  <= 1'b0;
      ram_cs_b  <= 1'b1;
      ram_oe_b  <= 1'b1;
      ram_we_b  <= 1'b1;
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: if (req) begin
          rnw_q    <= rnw;
          beat     <= '0;
          wcnt     <= '0;
          busy     <= 1'b1;
          state    <= SETUP;
          sram_adr <= beat_adr(addr, '0);
          ram_cs_b <= 1'b0;
          ram_we_b <= 1'b1;
          ram_oe_b <= !rnw;
          sram_den <= !rnw;
          if (!rnw) sram_dout <= slice_of(wdata, '0);
        end
        SETUP: begin
          wcnt  <= '0;
          state <= STROBE;
          if (!rnw_q) ram_we_b <= 1'b0;
        end
        STROBE: begin
          if (!strobe_last) begin
            wcnt <= wcnt + 1'b1;
          end else if (!rnw_q) begin
            ram_we_b <= 1'b1;
            state    <= HOLD;
          end else if (last_beat) begin
            rdata    <= merge(rbuf, beat, sram_din);
            ack      <= 1'b1;
            state    <= DONE;
            ram_cs_b <= 1'b1;
            ram_oe_b <= 1'b1;
          end else begin
            beat     <= beat_nx;
            state    <= SETUP;
            sram_adr <= beat_adr(addr_q, beat_nx);
          end
        end
        // Data and address stay put here so the SRAM latches them on the WE rising edge.
        HOLD: begin
          if (last_beat) begin
            ack      <= 1'b1;
            state    <= DONE;
            ram_cs_b <= 1'b1;
            sram_den <= 1'b0;
          end else begin
            beat      <= beat_nx;
            state     <= SETUP;
            sram_adr  <= beat_adr(addr_q, beat_nx);
            sram_dout <= slice_of(wdata_q, beat_nx);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Multi-beat bridge from a wide CPU data bus to a narrow asynchronous external SRAM.
- Parametrised successor to the hard-wired 16-bit SRAM hookup in the opc system tops.
- Splits one CPU access into BEATS = CPU_DW/SRAM_DW SRAM cycles and generates registered, glitch-free CS/OE/WE strobes with programmable wait states.
- Holds write data past the WE rising edge so the data pins never contend with the SRAM; reassembles read data and returns it with a one-cycle ack.

Parameters:
- CPU_DW, 32: CPU data width. Must equal SRAM_DW, 2×SRAM_DW or 4×SRAM_DW.
- SRAM_DW, 16: SRAM data width.
- CPU_AW, 20: CPU word-address width.
- SRAM_AW, 18: SRAM address width.
- WAIT_STATES, 1: extra strobe cycles per beat (0..15).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- req, in, 1: access request. Held high until ack.
- rnw, in, 1: 1 = read, 0 = write. Sampled when the request is accepted.
- addr, in, CPU_AW: CPU word address. Sampled when the request is accepted.
- wdata, in, CPU_DW: write data. Sampled when the request is accepted.
- rdata, out, CPU_DW: assembled read data. Valid in the ack cycle; held until the next read completes.
- ack, out, 1: one-cycle completion pulse.
- busy, out, 1: high from acceptance through the ack cycle.
- sram_adr, out, SRAM_AW: SRAM address.
- sram_dout, out, SRAM_DW: data to the pad drivers.
- sram_den, out, 1: pad output enable.
- sram_din, in, SRAM_DW: data from the pads.
- ram_cs_b, out, 1: SRAM chip select, active low.
- ram_oe_b, out, 1: SRAM output enable, active low.
- ram_we_b, out, 1: SRAM write enable, active low.

Behaviour:
- Register rules:
  - All outputs are registered.
  - Reset values: ack=0, busy=0, rdata=0, sram_adr=0, sram_dout=0, sram_den=0, ram_cs_b=1, ram_oe_b=1, ram_we_b=1.
  - Reset takes effect on the next edge from any state. An in-flight access is abandoned: no ack, strobes deasserted, sram_den=0.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - If req=1: latch rnw, addr, wdata; clear beat counter; go to SETUP.
  - The request is accepted in the same cycle req is first seen in IDLE.
- SETUP (1 cycle):
  - sram_adr = {addr, beat} truncated to the low SRAM_AW bits. For BEATS=1 there is no beat field.
  - ram_cs_b=0, ram_we_b=1.
  - Read: ram_oe_b=0, sram_den=0.
  - Write: ram_oe_b=1, sram_den=1, sram_dout = wdata slice[beat].
- STROBE (WAIT_STATES+1 cycles, counted by a wait counter):
  - Write: ram_we_b=0.
  - Read: ram_oe_b stays 0; sram_din is captured into rdata slice[beat] on the last STROBE cycle.
  - Reads then advance the beat (back to SETUP) or go to DONE after the last beat.
  - Writes go to HOLD.
- HOLD (writes only, 1 cycle):
  - ram_we_b=1; sram_den, sram_dout and sram_adr unchanged.
  - Then advance the beat (back to SETUP) or go to DONE.
- DONE (1 cycle):
  - ack=1, busy=1, all strobes inactive, sram_den=0.
  - Return to IDLE. req is ignored in DONE.
  - The master drops req on seeing ack. If req is still high in the following IDLE cycle, that starts a new access.
- Ordering and latency:
  - Beat 0 maps to slice [SRAM_DW-1:0], i.e. little-endian.
  - Latency from the req cycle (cycle 0) to the ack cycle:
    - Read: BEATS×(2+WAIT_STATES)+1.
    - Write: BEATS×(3+WAIT_STATES)+1.
- Bus-contention rules:
  - sram_den=1 only in SETUP/STROBE/HOLD of a write.
  - ram_oe_b=0 only in SETUP/STROBE of a read.
  - The two are never simultaneously active.
  - At least one cycle (DONE) separates any read strobe from the next write drive.
- Address wrap: address bits above SRAM_AW are discarded. No error is flagged.
- Changes on addr, wdata or rnw after acceptance have no effect.
- busy=0 only in IDLE.

Test Plan:
- Reset values:
  - Stimulus: hold reset 2 cycles with req=1.
  - Required: all outputs at reset values; ram_cs_b/ram_oe_b/ram_we_b=1; no access starts while reset=1.
- 32-bit write, default parameters:
  - Stimulus: write addr=0x00010, wdata=0xDEADBEEF to an SRAM behavioural model.
  - Required: SRAM word 0x00020 = 0xBEEF, word 0x00021 = 0xDEAD.
  - Required: ram_we_b low exactly 2 cycles per beat; sram_den high for 4 cycles per beat; ack in cycle 9.
- 32-bit read, default parameters:
  - Stimulus: read back addr=0x00010.
  - Required: rdata=0xDEADBEEF with ack in cycle 7; ram_oe_b low 3 cycles per beat; sram_den=0 throughout.
- WAIT_STATES=0, back-to-back traffic:
  - Stimulus: write 0x12345678 then read, with req re-asserted immediately after each ack.
  - Required: ack in cycles 7 and 5 of each access; no cycle with sram_den=1 and ram_oe_b=0 together.
- Reset mid-write:
  - Stimulus: assert reset during the beat-1 STROBE.
  - Required: next cycle ram_we_b=1, sram_den=0, ack never asserted.
  - Required: a subsequent read of the same address returns the new low half and the old high half.
- Address truncation and BEATS=1:
  - Stimulus: CPU_DW=16, CPU_AW=20, SRAM_AW=18; write addr=0xC0005, data 0xA5A5.
  - Required: sram_adr=0x00005; ack in cycle 5; a read of addr=0x00005 returns 0xA5A5.
